// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC sequencer: FSM encoding,
// output-dimension formula and a counter-sizing helper.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_OUT,
    ST_DONE
  } state_t;

  function automatic int out_dim(input int img, input int ker, input int pad, input int stride);
    return (img - ker + 2 * pad) / stride + 1;
  endfunction

  // Bits needed to count 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate: sum = acc + sext(a*b), acc registered.
// Clear has priority over enable; overflow wraps at acc_width.
module conv_mac_unit #(
  parameter int bitwidth  = 3,
  parameter int acc_width = 16
) (
  input  logic                        clk_en,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [bitwidth-1:0]  a,
  input  logic signed [bitwidth-1:0]  b,
  output logic signed [acc_width-1:0] sum
);

  logic signed [2*bitwidth-1:0] prod;
  logic signed [acc_width-1:0]  acc;

  assign prod = (2*bitwidth)'(a) * (2*bitwidth)'(b);
  assign sum  = acc + acc_width'(prod);

  always_ff @(posedge clk_en) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/conv_mac_seq.sv
// Walks output pixels in raster order, steps the kernel window row-major and
// emits one dot product per pixel; OUT holds until result_ready (K+2 cycles/result).
module conv_mac_seq
  import conv_pkg::*;
#(
  parameter int weight_width  = 2,
  parameter int weight_height = 2,
  parameter int img_width     = 4,
  parameter int img_height    = 4,
  parameter int padding       = 0,
  parameter int stride        = 1,
  parameter int bitwidth      = 3,
  parameter int acc_width     = 16,
  parameter int result_width  = out_dim(img_width, weight_width, padding, stride),
  parameter int result_height = out_dim(img_height, weight_height, padding, stride)
) (
  input  logic                        clk_en,
  input  logic                        rst,
  input  logic                        start,
  output logic                        conv_on,
  output logic [31:0]                 anchor_l,
  output logic [31:0]                 anchor_c,
  output logic [3:0]                  buf_l,
  output logic [3:0]                  buf_c,
  input  logic signed [bitwidth-1:0]  img_cal,
  input  logic signed [bitwidth-1:0]  wei_cal,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic signed [acc_width-1:0] result_data,
  output logic [15:0]                 result_l,
  output logic [15:0]                 result_c,
  output logic                        busy,
  output logic                        done
);

  localparam int CW = clog2((result_width > result_height) ? result_width : result_height);

  state_t                      state, state_nxt;
  logic [CW-1:0]               out_row, out_col;
  logic [3:0]                  k_l, k_c;
  logic                        k_last, k_row_end, col_last, row_last, hs;
  logic                        acc_clr, acc_en;
  logic signed [acc_width-1:0] acc_sum;

  assign k_row_end = (k_c == 4'(weight_width - 1));
  assign k_last    = k_row_end && (k_l == 4'(weight_height - 1));
  assign col_last  = (out_col == CW'(result_width - 1));
  assign row_last  = (out_row == CW'(result_height - 1));
  assign hs        = result_valid && result_ready;

  assign acc_clr = (state == ST_LOAD);
  assign acc_en  = (state == ST_MAC);

  conv_mac_unit #(
    .bitwidth (bitwidth),
    .acc_width(acc_width)
  ) u_mac (
    .clk_en(clk_en),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (acc_en),
    .a     (img_cal),
    .b     (wei_cal),
    .sum   (acc_sum)
  );

  always_comb begin
    state_nxt = state;
    conv_on   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        conv_on   = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_MAC;
      end
      ST_MAC: begin
        conv_on = 1'b1;
        busy    = 1'b1;
        if (k_last) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        conv_on = 1'b1;
        busy    = 1'b1;
        if (hs) state_nxt = (row_last && col_last) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign anchor_l = 32'(out_row) * 32'(stride);
  assign anchor_c = 32'(out_col) * 32'(stride);
  assign buf_l    = k_l;
  assign buf_c    = k_c;

  always_ff @(posedge clk_en) begin
    if (rst) begin
      state        <= ST_IDLE;
      out_row      <= '0;
      out_col      <= '0;
      k_l          <= '0;
      k_c          <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_l     <= '0;
      result_c     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_MAC) begin
        if (k_last) begin
          k_l          <= '0;
          k_c          <= '0;
          result_data  <= acc_sum;
          result_l     <= 16'(out_row);
          result_c     <= 16'(out_col);
          result_valid <= 1'b1;
        end else if (k_row_end) begin
          k_c <= '0;
          k_l <= k_l + 4'd1;
        end else begin
          k_c <= k_c + 4'd1;
        end
      end
      // Counters wrap to zero after the last pixel, so IDLE always restarts at (0,0).
      if (state == ST_OUT && hs) begin
        result_valid <= 1'b0;
        if (col_last) begin
          out_col <= '0;
          out_row <= row_last ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

endmodule
